// File: rtl/chaos_keystream_gen_if.sv
// Keystream handshake bundle between the chaos keystream source and its consumer.
// XW/YW/ZW must match the coordinate widths the generator derives from its extents.
interface chaos_keystream_gen_if #(
    parameter int XW = 2,
    parameter int YW = 2,
    parameter int ZW = 2
);
    logic          start;
    logic [127:0]  K;
    logic [7:0]    F;
    logic          ks_valid;
    logic          ks_ready;
    logic [7:0]    ks_byte;
    logic [XW-1:0] ks_x;
    logic [YW-1:0] ks_y;
    logic [ZW-1:0] ks_z;
    logic          ks_last;
    logic          busy;
    logic          done;

    modport master (
        output start, K, F, ks_ready,
        input  ks_valid, ks_byte, ks_x, ks_y, ks_z, ks_last, busy, done
    );

    modport slave (
        input  start, K, F, ks_ready,
        output ks_valid, ks_byte, ks_x, ks_y, ks_z, ks_last, busy, done
    );
endinterface

// File: rtl/chaos_keystream_gen.sv
// Logistic-map keystream source: seeds from the key, discards WARMUP iterations,
// then streams one masked byte per handshake in z-fastest raster order.
module chaos_keystream_gen #(
    parameter int MAX_X  = 4,
    parameter int MAX_Y  = 4,
    parameter int MAX_Z  = 3,
    parameter int WARMUP = 64
) (
    input logic clk,
    input logic rst_n,
    chaos_keystream_gen_if.slave ks
);
    localparam int XW = (MAX_X > 1) ? $clog2(MAX_X) : 1;
    localparam int YW = (MAX_Y > 1) ? $clog2(MAX_Y) : 1;
    localparam int ZW = (MAX_Z > 1) ? $clog2(MAX_Z) : 1;
    localparam int WW = $clog2(WARMUP + 1);

    typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   x, r;
    logic [7:0]    mask;
    logic [WW-1:0] wcnt;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [ZW-1:0] nz;
    logic [15:0]   x_next, seed;
    logic [3:0]    f_eff;
    logic [7:0]    mask_in;
    logic          slot_free, last_hs, at_end;

    // x_next = (r * x * (1 - x)) in Q0.16; r < 4 and x(1-x) <= 0.25 keep it in range
    function automatic logic [15:0] map_step(input logic [15:0] xv, input logic [15:0] rv);
        logic [16:0] om;
        logic [31:0] t;
        logic [47:0] p;
        om = 17'h10000 - {1'b0, xv};
        t  = {16'b0, xv} * {15'b0, om};
        p  = {32'b0, rv} * {16'b0, t};
        return 16'(p >> 30);
    endfunction

    assign x_next    = map_step(x, r);
    assign seed      = (ks.K[127:112] == 16'h0) ? 16'h5A5A : ks.K[127:112];
    assign f_eff     = (ks.F == 8'd0 || ks.F > 8'd8) ? 4'd8 : ks.F[3:0];
    assign mask_in   = 8'hFF >> (4'd8 - f_eff);
    assign slot_free = !ks.ks_valid || ks.ks_ready;
    assign last_hs   = ks.ks_valid && ks.ks_ready && ks.ks_last;
    assign at_end    = (nx == XW'(MAX_X - 1)) && (ny == YW'(MAX_Y - 1)) && (nz == ZW'(MAX_Z - 1));

    assign ks.busy = (state_q != S_IDLE);
    assign ks.done = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ks.start) state_d = S_WARM;
            S_WARM: if (wcnt == WW'(WARMUP - 1)) state_d = S_RUN;
            S_RUN:  if (last_hs) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            r           <= '0;
            mask        <= '0;
            wcnt        <= '0;
            nx          <= '0;
            ny          <= '0;
            nz          <= '0;
            ks.ks_valid <= 1'b0;
            ks.ks_byte  <= '0;
            ks.ks_x     <= '0;
            ks.ks_y     <= '0;
            ks.ks_z     <= '0;
            ks.ks_last  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (ks.start) begin
                    x           <= seed;
                    r           <= {3'b111, ks.K[111:99]};
                    mask        <= mask_in;
                    wcnt        <= '0;
                    nx          <= '0;
                    ny          <= '0;
                    nz          <= '0;
                    ks.ks_valid <= 1'b0;
                    ks.ks_last  <= 1'b0;
                end
                S_WARM: begin
                    x    <= x_next;
                    wcnt <= wcnt + 1'b1;
                end
                S_RUN: if (slot_free) begin
                    if (last_hs) begin
                        ks.ks_valid <= 1'b0;
                        ks.ks_last  <= 1'b0;
                    end else begin
                        // map advances only when a byte is loaded, so stalls freeze it
                        x           <= x_next;
                        ks.ks_byte  <= x_next[15:8] & mask;
                        ks.ks_x     <= nx;
                        ks.ks_y     <= ny;
                        ks.ks_z     <= nz;
                        ks.ks_last  <= at_end;
                        ks.ks_valid <= 1'b1;
                        if (nz == ZW'(MAX_Z - 1)) begin
                            nz <= '0;
                            if (ny == YW'(MAX_Y - 1)) begin
                                ny <= '0;
                                nx <= (nx == XW'(MAX_X - 1)) ? '0 : nx + 1'b1;
                            end else begin
                                ny <= ny + 1'b1;
                            end
                        end else begin
                            nz <= nz + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chaos_keystream_gen.sv
// Scoreboard bench for chaos_keystream_gen: stimulus pushes expected bytes/coords,
// a negedge monitor pops and compares on every handshake.
module tb_chaos_keystream_gen;
    localparam int MX = 4, MY = 4, MZ = 3, WU = 1;
    localparam int TOTAL = MX * MY * MZ;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chaos_keystream_gen_if #(.XW(2), .YW(2), .ZW(2)) bus ();

    chaos_keystream_gen #(.MAX_X(MX), .MAX_Y(MY), .MAX_Z(MZ), .WARMUP(WU)) dut (
        .clk(clk), .rst_n(rst_n), .ks(bus)
    );

    typedef struct packed {
        logic [7:0] b;
        logic [1:0] x, y, z;
        logic       last;
    } exp_t;

    exp_t q[$];
    exp_t cur, e, held;
    int   total = 0, bad = 0, hs_cnt = 0, done_cnt = 0;
    bit   rand_rdy = 0, stall_prev = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Independent reference: r*x*(1-x) evaluated as one integer product, scaled back by 2^30
    function automatic logic [15:0] mstep(input logic [15:0] xv, input logic [15:0] rv);
        longint p;
        p = longint'(rv) * longint'(xv) * (longint'(65536) - longint'(xv));
        return 16'(p >>> 30);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            cur = exp_t'({bus.ks_byte, bus.ks_x, bus.ks_y, bus.ks_z, bus.ks_last});
            if (bus.ks_valid) begin
                if (stall_prev) check("stall_hold", 64'(cur), 64'(held));
                if (bus.ks_ready) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_byte: got %0h want none", cur);
                    end else begin
                        e = q.pop_front();
                        check("ks_out", 64'(cur), 64'(e));
                    end
                    hs_cnt++;
                    stall_prev = 0;
                end else begin
                    stall_prev = 1;
                    held = cur;
                end
            end else begin
                stall_prev = 0;
            end
            if (bus.done) done_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        bus.ks_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic push_exp(input logic [15:0] seed, input logic [15:0] rv, input logic [7:0] mask,
                            input bit use_first, input logic [7:0] f0, input logic [7:0] f1);
        logic [15:0] xm;
        exp_t ev;
        xm = seed;
        for (int i = 0; i < WU; i++) xm = mstep(xm, rv);
        for (int i = 0; i < TOTAL; i++) begin
            xm      = mstep(xm, rv);
            ev.b    = xm[15:8] & mask;
            if (use_first && i == 0) ev.b = f0;
            if (use_first && i == 1) ev.b = f1;
            ev.x    = 2'(i / (MY * MZ));
            ev.y    = 2'((i / MZ) % MY);
            ev.z    = 2'(i % MZ);
            ev.last = (i == TOTAL - 1);
            q.push_back(ev);
        end
    endtask

    task automatic do_start(input logic [127:0] key, input logic [7:0] f);
        @(posedge clk); #1;
        bus.K = key; bus.F = f; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_stream(input logic [127:0] key, input logic [7:0] f, input logic [15:0] seed,
                              input logic [7:0] mask, input bit use_first,
                              input logic [7:0] f0, input logic [7:0] f1, input bit inject);
        int hs0, dn0, cyc;
        push_exp(seed, {3'b111, key[111:99]}, mask, use_first, f0, f1);
        hs0 = hs_cnt; dn0 = done_cnt;
        do_start(key, f);
        check("busy_after_start", 64'(bus.busy), 64'd1);
        cyc = 0;
        while (!bus.ks_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("first_valid_latency", 64'(cyc), 64'(WU + 1));
        cyc = 0;
        while (!bus.done && cyc < 2000) begin
            @(posedge clk); #1; cyc++;
            if (inject && cyc == 15) begin
                bus.K = ~key; bus.F = 8'd3; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        if (!bus.done) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done want done within 2000 cycles");
        end
        @(posedge clk); #1;
        check("busy_after_done", 64'({bus.busy, bus.done}), 64'd0);
        check("handshake_count", 64'(hs_cnt - hs0), 64'(TOTAL));
        check("done_pulses", 64'(done_cnt - dn0), 64'd1);
        check("queue_drained", 64'(q.size()), 64'd0);
    endtask

    task automatic reset_mid_run(input logic [127:0] key, input logic [15:0] seed);
        int hs0, dn0, cyc;
        push_exp(seed, {3'b111, key[111:99]}, 8'hFF, 1'b0, 8'h0, 8'h0);
        hs0 = hs_cnt; dn0 = done_cnt;
        do_start(key, 8'd8);
        cyc = 0;
        while (hs_cnt - hs0 < 10 && cyc < 500) begin @(posedge clk); #1; cyc++; end
        check("pre_reset_progress", 64'(hs_cnt - hs0 >= 10), 64'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({bus.ks_valid, bus.ks_byte, bus.ks_x, bus.ks_y, bus.ks_z, bus.ks_last, bus.busy, bus.done}),
              64'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("no_done_on_reset", 64'(done_cnt - dn0), 64'd0);
    endtask

    logic [127:0] k1, k3, k4;

    initial begin
        bus.start = 1'b0; bus.K = '0; bus.F = '0; bus.ks_ready = 1'b1;
        #12;
        check("reset_state",
              64'({bus.ks_valid, bus.ks_byte, bus.ks_x, bus.ks_y, bus.ks_z, bus.ks_last, bus.busy, bus.done}),
              64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        k1 = {16'h8000, 13'h0000, 99'h0};
        run_stream(k1, 8'd8, 16'h8000, 8'hFF, 1'b1, 8'h62, 8'hD3, 1'b0);
        run_stream(k1, 8'd4, 16'h8000, 8'h0F, 1'b1, 8'h02, 8'h03, 1'b0);

        k3 = {16'h0000, 13'h1234, 99'h5};
        run_stream(k3, 8'd8, 16'h5A5A, 8'hFF, 1'b0, 8'h0, 8'h0, 1'b0);

        k4 = {16'h1357, 13'h0ABC, 99'h0};
        rand_rdy = 1;
        run_stream(k4, 8'd0, 16'h1357, 8'hFF, 1'b0, 8'h0, 8'h0, 1'b0);
        run_stream(k4, 8'd5, 16'h1357, 8'h1F, 1'b0, 8'h0, 8'h0, 1'b1);

        reset_mid_run(k4, 16'h1357);
        run_stream(k4, 8'd8, 16'h1357, 8'hFF, 1'b0, 8'h0, 8'h0, 1'b0);
        rand_rdy = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
